fm_freeze_ctrl: RTL and testbench
=================================

FM_FREEZE_CTRL -- requirements
Module: fm_freeze_ctrl

Interface
REQ-001 SHALL have parameter TOTAL_SB, default 8, meaning the number of spybuffers controlled (2..32).
REQ-002 SHALL have parameter POST_W, default 10, meaning the post-trigger counter width.
REQ-003 SHALL have port clk_hs  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_hs_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port arm  in  1  one-cycle pulse that arms capture.
REQ-006 SHALL have port release  in  1  one-cycle pulse that unfreezes and returns to IDLE.
REQ-007 SHALL have port sw_trig  in  1  software trigger pulse.
REQ-008 SHALL have port ext_trig  in  TOTAL_SB  per-spybuffer trigger pulses.
REQ-009 SHALL have port post_len  in  POST_W  post-trigger cycles; it is sampled on trigger.
REQ-010 SHALL have port rd_req  in  TOTAL_SB  readout request from each frozen spybuffer.
REQ-011 SHALL have port rd_done  in  1  pulse meaning the granted readout is complete.
REQ-012 SHALL have port freeze  out  TOTAL_SB  per-spybuffer freeze.
REQ-013 SHALL have port rd_gnt  out  TOTAL_SB  one-hot readout grant.
REQ-014 SHALL have port trig_src  out  TOTAL_SB  latched trigger source mask; bit set for each ext_trig, all bits set for sw_trig.
REQ-015 SHALL have port state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3.

Function
REQ-016 SHALL leave IDLE for ARMED on arm; all other inputs are ignored in IDLE.
REQ-017 SHALL leave ARMED for POST on any sw_trig or ext_trig bit. On that edge it latches trig_src as the OR of the sources and loads the counter with post_len.
REQ-018 SHALL decrement the counter each cycle in POST and enter FROZEN on the cycle after the counter reads 0; post_len=0 gives exactly 1 cycle in POST.
REQ-019 SHALL ignore triggers arriving in POST or FROZEN; trig_src is not modified.
REQ-020 SHALL drive freeze all-ones, registered, in FROZEN only and all-zeros in every other state.
REQ-021 In FROZEN, SHALL grant the lowest index with rd_req set, searching round-robin starting after the last granted index. There is a 1-cycle latency from rd_req to rd_gnt.
REQ-022 SHALL hold a grant stable until rd_done, regardless of rd_req deassertion. On rd_done the grant drops for one cycle before the next grant.
REQ-023 SHALL ignore rd_done when no grant is active.
REQ-024 On release, from any state except IDLE, SHALL go to IDLE next cycle and clear freeze, rd_gnt and trig_src. release has priority over arm, triggers and rd_done in the same cycle.
REQ-025 SHALL let arm in ARMED, POST or FROZEN have no effect.
REQ-026 SHALL let the round-robin pointer survive release and reset only with rst_hs_n.

Reset
REQ-027 While rst_hs_n=0, SHALL have state=IDLE, freeze=0, rd_gnt=0, trig_src=0, counter=0, round-robin pointer=TOTAL_SB-1 (so index 0 is first), and trig_count=0.
REQ-028 SHALL take effect immediately on assertion, including mid-POST or mid-grant, and release synchronously on the first clk_hs edge after deassertion.

Configuration
REQ-029 With macro FM_FREEZE_TRIG_CNT_EN defined, SHALL add output trig_count  out  16, counting accepted triggers (ARMED->POST transitions), saturating at 16'hFFFF, and not cleared by release.
REQ-030 Without FM_FREEZE_TRIG_CNT_EN, SHALL have no trig_count port or counter logic; all other behaviour is identical.

Verification
REQ-031 Bench SHALL cover: arm, then ext_trig=8'h04 with post_len=3 -> state POST for 4 cycles, freeze=8'hFF thereafter, trig_src=8'h04.
REQ-032 Bench SHALL cover: FROZEN with rd_req=8'h81 and pointer at reset -> rd_gnt=8'h01; after rd_done, one idle cycle, then rd_gnt=8'h80.
REQ-033 Bench SHALL cover: release and rd_done in the same cycle during a grant -> next cycle state=IDLE, rd_gnt=0, freeze=0.
REQ-034 Bench SHALL cover: rst_hs_n pulled low mid-POST asynchronously -> outputs zero before the next clk_hs edge, state=IDLE.
REQ-035 Bench SHALL cover: sw_trig and ext_trig=8'h10 together in ARMED -> trig_src=8'hFF; a second ext_trig in POST -> trig_src unchanged.
REQ-036 Bench SHALL cover, with FM_FREEZE_TRIG_CNT_EN: 3 arm/trigger/release cycles -> trig_count=3, and 16'hFFFF holds at saturation.

Source files
------------

// File: rtl/fm_freeze_ctrl.sv
// Spybuffer freeze controller: arm -> trigger -> post-trigger countdown -> freeze + round-robin readout.
// Optional FM_FREEZE_TRIG_CNT_EN adds a saturating accepted-trigger counter; release is a reserved word, so the pulse is release_req.
module fm_freeze_ctrl #(
  parameter int TOTAL_SB = 8,
  parameter int POST_W   = 10
) (
  input  logic                clk_hs,
  input  logic                rst_hs_n,
  input  logic                arm,
  input  logic                release_req,
  input  logic                sw_trig,
  input  logic [TOTAL_SB-1:0] ext_trig,
  input  logic [POST_W-1:0]   post_len,
  input  logic [TOTAL_SB-1:0] rd_req,
  input  logic                rd_done,
  output logic [TOTAL_SB-1:0] freeze,
  output logic [TOTAL_SB-1:0] rd_gnt,
  output logic [TOTAL_SB-1:0] trig_src,
  output logic [1:0]          state
`ifdef FM_FREEZE_TRIG_CNT_EN
  ,
  output logic [15:0]         trig_count
`endif
);

  localparam int PW = (TOTAL_SB > 1) ? $clog2(TOTAL_SB) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_FROZEN = 2'd3} state_t;

  state_t              cur, nxt;
  logic [POST_W-1:0]   cnt;
  logic [PW-1:0]       ptr;
  logic                trig, rel;
  logic [TOTAL_SB-1:0] pick;
  logic [PW-1:0]       pick_idx;
  logic                pick_vld;
  logic [PW:0]         sum;

  assign trig  = sw_trig | (|ext_trig);
  assign rel   = release_req & (cur != S_IDLE);
  assign state = cur;

  always_ff @(posedge clk_hs or negedge rst_hs_n) begin
    if (!rst_hs_n) cur <= S_IDLE;
    else           cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (rel) nxt = S_IDLE;
    else begin
      case (cur)
        S_IDLE:   if (arm) nxt = S_ARMED;
        S_ARMED:  if (trig) nxt = S_POST;
        S_POST:   if (cnt == '0) nxt = S_FROZEN;
        default:  nxt = cur;
      endcase
    end
  end

  // Round-robin search starts one past the last granted index.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    sum      = '0;
    for (int i = 1; i <= TOTAL_SB; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(TOTAL_SB)) sum = sum - (PW+1)'(TOTAL_SB);
      if (!pick_vld && rd_req[sum[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[PW-1:0];
      end
    end
    pick = pick_vld ? (TOTAL_SB'(1) << pick_idx) : '0;
  end

  always_ff @(posedge clk_hs or negedge rst_hs_n) begin
    if (!rst_hs_n) begin
      freeze   <= '0;
      rd_gnt   <= '0;
      trig_src <= '0;
      cnt      <= '0;
      ptr      <= PW'(TOTAL_SB - 1);
    end else if (rel) begin
      freeze   <= '0;
      rd_gnt   <= '0;
      trig_src <= '0;
      cnt      <= '0;
    end else begin
      freeze <= (nxt == S_FROZEN) ? '1 : '0;
      case (cur)
        S_ARMED: if (trig) begin
          trig_src <= ext_trig | {TOTAL_SB{sw_trig}};
          cnt      <= post_len;
        end
        S_POST: if (cnt != '0) cnt <= cnt - POST_W'(1);
        S_FROZEN: begin
          // A live grant is held until rd_done; the drop cycle separates grants.
          if (|rd_gnt) begin
            if (rd_done) rd_gnt <= '0;
          end else if (pick_vld) begin
            rd_gnt <= pick;
            ptr    <= pick_idx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FM_FREEZE_TRIG_CNT_EN
  logic [15:0] trig_cnt_q;
  assign trig_count = trig_cnt_q;

  always_ff @(posedge clk_hs or negedge rst_hs_n) begin
    if (!rst_hs_n) trig_cnt_q <= '0;
    else if (cur == S_ARMED && trig && !rel && trig_cnt_q != 16'hFFFF)
      trig_cnt_q <= trig_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fm_freeze_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of fm_freeze_ctrl.
module tb_fm_freeze_ctrl;
  localparam int N  = 8;
  localparam int PL = 10;

  logic          clk_hs = 1'b0, rst_hs_n = 1'b0;
  logic          arm = 1'b0, release_req = 1'b0, sw_trig = 1'b0, rd_done = 1'b0;
  logic [N-1:0]  ext_trig = '0, rd_req = '0;
  logic [PL-1:0] post_len = '0;
  logic [N-1:0]  freeze, rd_gnt, trig_src;
  logic [1:0]    state;
`ifdef FM_FREEZE_TRIG_CNT_EN
  logic [15:0]   trig_count;
`endif

  int checks = 0, errors = 0;

  // model state
  int           m_st, m_left, m_owner, m_last, m_tc;
  logic [N-1:0] m_src;

  fm_freeze_ctrl #(.TOTAL_SB(N), .POST_W(PL)) dut (
    .clk_hs(clk_hs), .rst_hs_n(rst_hs_n), .arm(arm), .release_req(release_req),
    .sw_trig(sw_trig), .ext_trig(ext_trig), .post_len(post_len), .rd_req(rd_req),
    .rd_done(rd_done), .freeze(freeze), .rd_gnt(rd_gnt), .trig_src(trig_src), .state(state)
`ifdef FM_FREEZE_TRIG_CNT_EN
    , .trig_count(trig_count)
`endif
  );

  always #5 clk_hs = ~clk_hs;

  task automatic clr_in();
    arm = 0; release_req = 0; sw_trig = 0; rd_done = 0;
    ext_trig = '0; rd_req = '0; post_len = '0;
  endtask

  task automatic tick();
    @(posedge clk_hs);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_hs_n = 0;
    #12;
    @(negedge clk_hs);
    rst_hs_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clr_in();
    rst_hs_n = 0;
    #12;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (freeze !== '0 || rd_gnt !== '0 || trig_src !== '0) begin
      errors++; $display("FAIL reset_outputs got fz=%h gnt=%h src=%h want 0", freeze, rd_gnt, trig_src); end
    @(negedge clk_hs);
    rst_hs_n = 1;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_idle got %0d want 0", state); end
  endtask

  task automatic test_post_len();
    arm = 1; tick(); arm = 0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL armed got %0d want 1", state); end
    ext_trig = 8'h04; post_len = 10'd3; tick(); ext_trig = '0; post_len = '0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (state !== 2'd2 || freeze !== '0) begin
        errors++; $display("FAIL post_cycle%0d got st=%0d fz=%h want st=2 fz=00", k, state, freeze); end
      ext_trig = (k == 1) ? 8'h20 : 8'h00;
      tick();
    end
    ext_trig = '0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL frozen_state got %0d want 3", state); end
    checks++; if (freeze !== 8'hFF) begin errors++; $display("FAIL frozen_freeze got %h want ff", freeze); end
    checks++; if (trig_src !== 8'h04) begin errors++; $display("FAIL trig_src_ext got %h want 04", trig_src); end
  endtask

  task automatic test_round_robin();
    rd_req = 8'h81; tick();
    checks++; if (rd_gnt !== 8'h01) begin errors++; $display("FAIL rr_first got %h want 01", rd_gnt); end
    rd_req = 8'h00; tick();
    checks++; if (rd_gnt !== 8'h01) begin errors++; $display("FAIL rr_hold got %h want 01", rd_gnt); end
    rd_req = 8'h81; rd_done = 1; tick(); rd_done = 0;
    checks++; if (rd_gnt !== 8'h00) begin errors++; $display("FAIL rr_gap got %h want 00", rd_gnt); end
    tick();
    checks++; if (rd_gnt !== 8'h80) begin errors++; $display("FAIL rr_second got %h want 80", rd_gnt); end
  endtask

  task automatic test_release_done();
    rd_done = 1; release_req = 1; tick(); clr_in();
    checks++; if (state !== 2'd0 || rd_gnt !== '0 || freeze !== '0 || trig_src !== '0) begin
      errors++; $display("FAIL release_done got st=%0d gnt=%h fz=%h src=%h want 0", state, rd_gnt, freeze, trig_src); end
  endtask

  task automatic test_sw_ext();
    arm = 1; tick(); arm = 0;
    sw_trig = 1; ext_trig = 8'h10; post_len = 10'd5; tick(); clr_in();
    checks++; if (state !== 2'd2 || trig_src !== 8'hFF) begin
      errors++; $display("FAIL sw_ext got st=%0d src=%h want st=2 src=ff", state, trig_src); end
    ext_trig = 8'h01; arm = 1; tick(); clr_in();
    checks++; if (state !== 2'd2 || trig_src !== 8'hFF) begin
      errors++; $display("FAIL post_retrig got st=%0d src=%h want st=2 src=ff", state, trig_src); end
    release_req = 1; arm = 1; tick(); clr_in();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL release_prio got %0d want 0", state); end
  endtask

  task automatic test_async_reset();
    arm = 1; tick(); arm = 0;
    ext_trig = 8'h02; post_len = 10'd20; tick(); clr_in(); tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_reset got %0d want 2", state); end
    #2 rst_hs_n = 0;
    #1;
    checks++; if (state !== 2'd0 || freeze !== '0 || rd_gnt !== '0 || trig_src !== '0) begin
      errors++; $display("FAIL async_reset got st=%0d fz=%h gnt=%h src=%h want 0", state, freeze, rd_gnt, trig_src); end
    @(negedge clk_hs);
    rst_hs_n = 1;
    tick();
  endtask

`ifdef FM_FREEZE_TRIG_CNT_EN
  task automatic test_trig_count();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      arm = 1; tick(); arm = 0;
      ext_trig = 8'h08; tick(); ext_trig = '0;
      release_req = 1; tick(); release_req = 0;
    end
    checks++; if (trig_count !== 16'd3) begin errors++; $display("FAIL trig_count got %0d want 3", trig_count); end
    dut.trig_cnt_q = 16'hFFFE;
    for (int r = 0; r < 2; r++) begin
      arm = 1; tick(); arm = 0;
      sw_trig = 1; tick(); sw_trig = 0;
      release_req = 1; tick(); release_req = 0;
    end
    checks++; if (trig_count !== 16'hFFFF) begin errors++; $display("FAIL trig_sat got %h want ffff", trig_count); end
  endtask
`endif

  task automatic model_reset();
    m_st = 0; m_left = 0; m_owner = -1; m_last = N - 1; m_tc = 0; m_src = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (release_req && m_st != 0) begin
      m_st = 0; m_src = '0; m_owner = -1;
    end else begin
      case (m_st)
        0: if (arm) m_st = 1;
        1: if (sw_trig || ext_trig != '0) begin
             m_st = 2; m_left = int'(post_len);
             m_src = sw_trig ? '1 : ext_trig;
             if (m_tc < 65535) m_tc++;
           end
        2: if (m_left == 0) m_st = 3; else m_left--;
        3: if (m_owner >= 0) begin
             if (rd_done) m_owner = -1;
           end else if (rd_req != '0) begin
             for (int k = 1; k <= N; k++)
               if (m_owner < 0 && rd_req[(m_last + k) % N]) m_owner = (m_last + k) % N;
             m_last = m_owner;
           end
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    logic [N-1:0] e_gnt, e_fz;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      arm         = ($urandom_range(0, 3) == 0);
      release_req = ($urandom_range(0, 29) == 0);
      sw_trig     = ($urandom_range(0, 19) == 0);
      ext_trig    = ($urandom_range(0, 5) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      post_len    = PL'($urandom_range(0, 6));
      rd_req      = N'($urandom);
      rd_done     = ($urandom_range(0, 2) == 0);
      model_step();
      tick();
      e_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
      e_fz  = (m_st == 3) ? '1 : '0;
      checks++; if (state !== 2'(m_st)) begin errors++; $display("FAIL rnd_state c%0d got %0d want %0d", c, state, m_st); end
      checks++; if (freeze !== e_fz) begin errors++; $display("FAIL rnd_freeze c%0d got %h want %h", c, freeze, e_fz); end
      checks++; if (rd_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %h want %h", c, rd_gnt, e_gnt); end
      checks++; if (trig_src !== m_src) begin errors++; $display("FAIL rnd_src c%0d got %h want %h", c, trig_src, m_src); end
`ifdef FM_FREEZE_TRIG_CNT_EN
      checks++; if (trig_count !== 16'(m_tc)) begin errors++; $display("FAIL rnd_tcnt c%0d got %0d want %0d", c, trig_count, m_tc); end
`endif
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_post_len();
    test_round_robin();
    test_release_done();
    test_sw_ext();
    test_async_reset();
`ifdef FM_FREEZE_TRIG_CNT_EN
    test_trig_count();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
